uart_monitor: RTL
=================

# uart_monitor

Host-side command sequencer for the toy MCU. Parses a byte stream from the UART receiver, loads and reads back the 256×16 word memory, and starts or stops the core. It also owns memory arbitration: it drives the memory only while the core is stopped. Sits between the UART rx/tx pair and the core/memory inside `toy`.

## Interface
- `TIMEOUT`, default 65535: idle cycles between bytes of one command before the command is abandoned. 0 disables the timeout.
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rx_valid`  in  1  one-cycle strobe; `rx_data` holds a received byte
- `rx_data`  in  8  received byte
- `tx_ready`  in  1  transmitter idle
- `tx_go`  out  1  one-cycle start pulse to the transmitter
- `tx_data`  out  8  byte to send; stable on the `tx_go` cycle
- `mem_sel`  out  1  1 = monitor owns memory, 0 = core owns it
- `mem_we`  out  1  write strobe, one cycle
- `mem_re`  out  1  read strobe, one cycle
- `mem_addr`  out  8  word address
- `mem_wdata`  out  16  write data
- `mem_rdata`  in  16  read data, valid the cycle after `mem_re` (synchronous RAM)
- `cpu_run`  out  1  core enable level
- `cpu_load`  out  1  one-cycle pulse: core loads PC from `cpu_pc`
- `cpu_pc`  out  8  start address
- `cpu_halted`  in  1  core has executed a halt

## Operation
- Internal 8-bit pointer `ptr`. Every memory access uses `mem_addr = ptr`. `ptr` increments after each access and wraps from 0xFF to 0x00.
- Commands, case-sensitive ASCII:
  - `'a' A`: `ptr <= A`.
  - `'w' H L`: write `{H,L}` at `ptr`, then `ptr++`.
  - `'r'`: read at `ptr`, transmit high byte then low byte, then `ptr++`.
  - `'e'`: `cpu_pc <= ptr`, pulse `cpu_load`, then `cpu_run <= 1`.
  - `'s'`: only accepted while running. Sets `cpu_run <= 0` and transmits `'S'`.
  - Any other byte in IDLE: transmit `'?'`.
- States and transitions:
  - IDLE: branches on the command byte.
  - GET_A: next byte → `ptr`, return to IDLE.
  - GET_H: next byte latched as high byte, go to GET_L.
  - GET_L: next byte latched as low byte, go to WR.
  - WR: pulse `mem_we`, go to IDLE.
  - RD: pulse `mem_re`, go to RD_W.
  - RD_W: latch `mem_rdata`, go to TX_H.
  - TX_H: send high byte, go to TX_L.
  - TX_L: send low byte, go to IDLE.
  - LOAD: pulse `cpu_load`, go to RUN.
  - RUN: on `'s'` or `cpu_halted` rising edge, go to TX_ACK.
  - TX_ACK: send the ack byte, go to IDLE.
- Core halt while in RUN: `cpu_run <= 0` and transmit `'H'`.
- `mem_sel = 0` exactly while `cpu_run = 1`. The monitor never strobes memory while `mem_sel = 0`.
- In RUN, every byte except `'s'` is dropped with no response.
- Bytes arriving in WR, RD, RD_W, TX_*, LOAD or TX_ACK are dropped.
- Timeout applies in GET_A, GET_H and GET_L only. After `TIMEOUT` cycles with no `rx_valid`, the partial command is discarded and the state returns to IDLE with no memory write and no response. The counter restarts on every accepted byte.

## Timing
- Reset values:
  - Outputs: `tx_go=0`, `tx_data=0`, `mem_sel=1`, `mem_we=0`, `mem_re=0`, `mem_addr=0`, `mem_wdata=0`, `cpu_run=0`, `cpu_load=0`, `cpu_pc=0`.
  - Internal: `ptr=0`, state IDLE.
- Reset mid-operation: everything returns to reset values immediately. An in-flight command is lost and no memory strobe is issued.
- Write latency: `mem_we` is asserted the cycle after the `rx_valid` carrying L.
- Read: `mem_re` the cycle after `'r'` is received, data latched one cycle later. The first `tx_go` occurs in the first cycle after that in which `tx_ready=1`.
- Tx handshake:
  - `tx_go` is pulsed only when `tx_ready=1`.
  - After a pulse, `tx_ready` is ignored for the following 2 cycles, then the block waits for `tx_ready=1` before the next byte.
- `'e'`: `cpu_load` the cycle after receipt, `cpu_run=1` the following cycle.
- `cpu_halted` is edge-detected with 1 cycle of latency.
- Simultaneous `'s'` and halt edge: halt takes priority. Exactly one `'H'` is sent, not `'S'`.
- `cpu_halted` already high when `'e'` runs: the core is still started. Only a new rising edge ends RUN.

## Test plan
- `'a' 0x10`, `'w' 0x12 0x34` → one `mem_we` with addr 0x10, wdata 0x1234; `ptr` = 0x11.
- `'a' 0xFF`, `'w' 0xAB 0xCD`, `'r'` → write lands at 0xFF. The read uses addr 0x00 (wrap), and transmits the two bytes of the RAM model at 0x00, high byte first, each `tx_go` only when `tx_ready=1`.
- `'a' 0x05`, `'e'` → `cpu_pc`=0x05, one `cpu_load` pulse, `cpu_run`=1, `mem_sel`=0. A `'w'` sent now causes no memory strobe. Raising `cpu_halted` → `cpu_run`=0 and `'H'` transmitted.
- `'w' 0x01` then silence for `TIMEOUT`+1 cycles (TIMEOUT=100 in bench) → no `mem_we`, state IDLE. A following `'r'` works normally.
- Byte `'x'` in IDLE → `'?'` transmitted. `'s'` and a `cpu_halted` edge in the same cycle during RUN → only `'H'` sent.
- `rst` asserted between the H and L bytes of a `'w'` → no `mem_we`. Outputs read reset values within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_monitor.sv
// rtl/uart_monitor.sv - UART command sequencer for the toy MCU: memory load/readback and core run control.
// Owns the memory port whenever the core is stopped; mem_addr always mirrors the internal pointer.
module uart_monitor #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_go,
  output logic [7:0]  tx_data,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        cpu_run,
  output logic        cpu_load,
  output logic [7:0]  cpu_pc,
  input  logic        cpu_halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_A, S_GET_H, S_GET_L, S_WR, S_RD, S_RD_W,
    S_TX_H, S_TX_L, S_LOAD, S_RUN, S_TX_ACK
  } state_t;

  localparam logic [7:0] CH_A = 8'h61;
  localparam logic [7:0] CH_W = 8'h77;
  localparam logic [7:0] CH_R = 8'h72;
  localparam logic [7:0] CH_E = 8'h65;
  localparam logic [7:0] CH_S = 8'h73;
  localparam logic [7:0] RSP_UNK  = 8'h3F;
  localparam logic [7:0] RSP_HALT = 8'h48;
  localparam logic [7:0] RSP_STOP = 8'h53;

  state_t      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  rd_lo_q, rd_lo_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [1:0]  hold_q, hold_d;
  logic [31:0] to_q, to_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_sel_q, mem_sel_d;
  logic        cpu_run_q, cpu_run_d;
  logic        cpu_load_q, cpu_load_d;
  logic [7:0]  cpu_pc_q, cpu_pc_d;
  logic        halt_prev_q;

  logic tx_state;
  logic halt_edge;
  logic timed_out;

  assign tx_state  = (state_q == S_TX_H) || (state_q == S_TX_L) || (state_q == S_TX_ACK);
  // tx_go stays combinational so a pulse can only coincide with tx_ready=1 in the same cycle.
  assign tx_go     = tx_state && tx_ready && (hold_q == 2'd0);
  assign halt_edge = cpu_halted && !halt_prev_q;
  assign timed_out = (TIMEOUT != 0) && (to_q == TIMEOUT - 32'd1);

  assign tx_data   = tx_data_q;
  assign mem_sel   = mem_sel_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = ptr_q;
  assign mem_wdata = wdata_q;
  assign cpu_run   = cpu_run_q;
  assign cpu_load  = cpu_load_q;
  assign cpu_pc    = cpu_pc_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wdata_d    = wdata_q;
    rd_lo_d    = rd_lo_q;
    tx_data_d  = tx_data_q;
    hold_d     = (hold_q == 2'd0) ? 2'd0 : hold_q - 2'd1;
    to_d       = to_q + 32'd1;
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;
    cpu_run_d  = cpu_run_q;
    cpu_load_d = 1'b0;
    cpu_pc_d   = cpu_pc_q;
    if (tx_go) hold_d = 2'd2;

    case (state_q)
      S_IDLE: begin
        to_d = 32'd0;
        if (rx_valid) begin
          case (rx_data)
            CH_A: state_d = S_GET_A;
            CH_W: state_d = S_GET_H;
            CH_R: begin
              state_d  = S_RD;
              mem_re_d = 1'b1;
            end
            CH_E: begin
              state_d    = S_LOAD;
              cpu_load_d = 1'b1;
              cpu_pc_d   = ptr_q;
            end
            default: begin
              state_d   = S_TX_ACK;
              tx_data_d = RSP_UNK;
            end
          endcase
        end
      end
      S_GET_A, S_GET_H, S_GET_L: begin
        if (rx_valid) begin
          to_d = 32'd0;
          if (state_q == S_GET_A) begin
            ptr_d   = rx_data;
            state_d = S_IDLE;
          end else if (state_q == S_GET_H) begin
            wdata_d[15:8] = rx_data;
            state_d       = S_GET_L;
          end else begin
            wdata_d[7:0] = rx_data;
            mem_we_d     = 1'b1;
            state_d      = S_WR;
          end
        end else if (timed_out) begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        ptr_d   = ptr_q + 8'd1;
        state_d = S_IDLE;
      end
      S_RD: begin
        ptr_d   = ptr_q + 8'd1;
        state_d = S_RD_W;
      end
      S_RD_W: begin
        tx_data_d = mem_rdata[15:8];
        rd_lo_d   = mem_rdata[7:0];
        state_d   = S_TX_H;
      end
      S_TX_H: begin
        if (tx_go) begin
          tx_data_d = rd_lo_q;
          state_d   = S_TX_L;
        end
      end
      S_TX_L, S_TX_ACK: begin
        if (tx_go) state_d = S_IDLE;
      end
      S_LOAD: begin
        cpu_run_d = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        // A halt edge wins over a simultaneous 's'.
        if (halt_edge) begin
          cpu_run_d = 1'b0;
          tx_data_d = RSP_HALT;
          state_d   = S_TX_ACK;
        end else if (rx_valid && rx_data == CH_S) begin
          cpu_run_d = 1'b0;
          tx_data_d = RSP_STOP;
          state_d   = S_TX_ACK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_sel_d = !cpu_run_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 8'd0;
      wdata_q     <= 16'd0;
      rd_lo_q     <= 8'd0;
      tx_data_q   <= 8'd0;
      hold_q      <= 2'd0;
      to_q        <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_sel_q   <= 1'b1;
      cpu_run_q   <= 1'b0;
      cpu_load_q  <= 1'b0;
      cpu_pc_q    <= 8'd0;
      halt_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wdata_q     <= wdata_d;
      rd_lo_q     <= rd_lo_d;
      tx_data_q   <= tx_data_d;
      hold_q      <= hold_d;
      to_q        <= to_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_sel_q   <= mem_sel_d;
      cpu_run_q   <= cpu_run_d;
      cpu_load_q  <= cpu_load_d;
      cpu_pc_q    <= cpu_pc_d;
      halt_prev_q <= cpu_halted;
    end
  end

endmodule
